// File: rtl/ads7950_pkg.sv
// Shared constants for the ADS7950 SPI responder: frame size, command
// field positions, mode codes and the frame FSM state type.
package ads7950_pkg;

   localparam int FRAME_BITS = 16;

   localparam logic [3:0] MODE_CONTINUE = 4'b0000;
   localparam logic [3:0] MODE_MANUAL   = 4'b0001;

   localparam int MODE_HI  = 15;
   localparam int MODE_LO  = 12;
   localparam int PROG_BIT = 11;
   localparam int CHAN_HI  = 10;
   localparam int CHAN_LO  = 7;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DONE,
      ST_ABORT
   } state_t;

endpackage

// File: rtl/spi_input_sync.sv
// Brings sclk/ss/mosi into the clk domain and flags sclk/ss edges.
// Edge strobes are combinational off the last sync flop; consumers register them.
module spi_input_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic sclk,
   input  logic ss,
   input  logic mosi,
   output logic sclk_rise,
   output logic sclk_fall,
   output logic ss_fall,
   output logic ss_rise,
   output logic mosi_s
);

   logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
   logic                   sclk_d, ss_d;

   // ss resets high so that leaving reset with the bus idle is not seen as a select
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sync <= '0;
         ss_sync   <= '1;
         mosi_sync <= '0;
         sclk_d    <= 1'b0;
         ss_d      <= 1'b1;
      end else begin
         sclk_sync <= (sclk_sync << 1) | SYNC_STAGES'(sclk);
         ss_sync   <= (ss_sync   << 1) | SYNC_STAGES'(ss);
         mosi_sync <= (mosi_sync << 1) | SYNC_STAGES'(mosi);
         sclk_d    <= sclk_sync[SYNC_STAGES-1];
         ss_d      <= ss_sync[SYNC_STAGES-1];
      end
   end

   assign sclk_rise =  sclk_sync[SYNC_STAGES-1] & ~sclk_d;
   assign sclk_fall = ~sclk_sync[SYNC_STAGES-1] &  sclk_d;
   assign ss_fall   = ~ss_sync[SYNC_STAGES-1]   &  ss_d;
   assign ss_rise   =  ss_sync[SYNC_STAGES-1]   & ~ss_d;
   assign mosi_s    =  mosi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ads7950_spi_responder.sv
// ADS7950 manual-mode SPI slave model: decodes channel commands and returns
// channel-tagged 12-bit samples with the two-frame acquisition pipeline.
module ads7950_spi_responder #(
   parameter int NUM_CH      = 4,
   parameter int FRAME_BITS  = ads7950_pkg::FRAME_BITS,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sclk,
   input  logic                 ss,
   input  logic                 mosi,
   output logic                 miso,
   input  logic [NUM_CH*12-1:0] adc_data,
   output logic [15:0]          cmd_word,
   output logic                 cmd_valid,
   output logic                 frame_err,
   output logic [15:0]          frame_count
);
   import ads7950_pkg::*;

   localparam int CW = $clog2(FRAME_BITS + 1);
   localparam logic [CW-1:0] FULL = CW'(FRAME_BITS);

   logic          sclk_rise, sclk_fall, ss_fall, ss_rise, mosi_s;
   state_t        state;
   logic [15:0]   tx_shift, rx_shift;
   logic [CW-1:0] bit_cnt;
   logic [3:0]    pending_ch, acq_ch;

   spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .rst       (rst),
      .sclk      (sclk),
      .ss        (ss),
      .mosi      (mosi),
      .sclk_rise (sclk_rise),
      .sclk_fall (sclk_fall),
      .ss_fall   (ss_fall),
      .ss_rise   (ss_rise),
      .mosi_s    (mosi_s)
   );

   // Unimplemented channel addresses read back as zero
   function automatic logic [11:0] sample(input logic [3:0] ch,
                                          input logic [NUM_CH*12-1:0] d);
      sample = '0;
      for (int k = 0; k < NUM_CH; k++)
         if (ch == 4'(k)) sample = d[k*12 +: 12];
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         miso        <= 1'b0;
         cmd_word    <= '0;
         cmd_valid   <= 1'b0;
         frame_err   <= 1'b0;
         frame_count <= '0;
         pending_ch  <= '0;
         acq_ch      <= '0;
         tx_shift    <= '0;
         rx_shift    <= '0;
         bit_cnt     <= '0;
      end else begin
         cmd_valid <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               // Return the channel acquired last frame; start acquiring the programmed one
               if (ss_fall) begin
                  tx_shift <= {acq_ch, sample(acq_ch, adc_data)};
                  miso     <= acq_ch[3];
                  acq_ch   <= pending_ch;
                  bit_cnt  <= '0;
                  state    <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (ss_rise) begin
                  miso  <= 1'b0;
                  state <= (bit_cnt == FULL) ? ST_DONE : ST_ABORT;
               end else begin
                  if (sclk_rise && bit_cnt != FULL) begin
                     rx_shift <= {rx_shift[14:0], mosi_s};
                     bit_cnt  <= bit_cnt + 1'b1;
                  end
                  // Zero fill means miso reads 0 once all 16 bits have gone out
                  if (sclk_fall) begin
                     tx_shift <= {tx_shift[14:0], 1'b0};
                     miso     <= tx_shift[14];
                  end
               end
            end
            ST_DONE: begin
               cmd_word    <= rx_shift;
               cmd_valid   <= 1'b1;
               frame_count <= frame_count + 16'd1;
               if (rx_shift[MODE_HI:MODE_LO] == MODE_MANUAL && rx_shift[PROG_BIT])
                  pending_ch <= rx_shift[CHAN_HI:CHAN_LO];
               state <= ST_IDLE;
            end
            ST_ABORT: begin
               frame_err <= 1'b1;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/ads7950_spi_responder.md
Name: ads7950_spi_responder

Overview:
- Synthesizable SPI slave that models the ADS7950 4-channel, 12-bit ADC on the system clock domain.
- Acts as the responder end of the board's SPI master link (sclk/mosi/ss/miso).
- Used for on-FPGA loopback and simulation of the ADC path, with no hardware ADC attached.
- Decodes manual-mode channel commands and returns channel-tagged 12-bit words with the ADS7950 two-frame pipeline latency.

Parameters:
- NUM_CH, 4, number of implemented channels; valid addresses are 0..NUM_CH-1.
- FRAME_BITS, 16, SPI frame length in bits.
- SYNC_STAGES, 2, synchronizer depth on sclk/ss/mosi.

Ports:
- clk  input  1  system clock; must run at least 8x sclk.
- rst  input  1  reset, synchronous, active-high.
- sclk  input  1  SPI clock from master; idle low, mode 0.
- ss  input  1  slave select, active low.
- mosi  input  1  command data from master.
- miso  output  1  response data to master.
- adc_data  input  NUM_CH*12  per-channel sample values; ch k occupies bits [12k+11:12k].
- cmd_word  output  16  last complete command received.
- cmd_valid  output  1  one-clk pulse when cmd_word updates.
- frame_err  output  1  one-clk pulse on an aborted frame.
- frame_count  output  16  number of complete frames; wraps 0xFFFF->0.

Behaviour:
- Reset values: miso=0, cmd_word=0, cmd_valid=0, frame_err=0, frame_count=0, pending_ch=0, acq_ch=0, state=IDLE. rst mid-frame returns to IDLE immediately, and the frame in progress is discarded without asserting frame_err.
- Input conditioning: sclk, ss and mosi each pass through SYNC_STAGES flops. Edge detect happens on the synchronized sclk and ss. Edge-to-action latency is SYNC_STAGES+1 clk.
- States: IDLE, then SHIFT on ss falling, then DONE or ABORT on ss rising, then IDLE.
- ss falling (IDLE->SHIFT):
  - tx_shift <= {acq_ch[3:0], sample(acq_ch)}.
  - acq_ch <= pending_ch.
  - bit_cnt <= 0.
  - miso drives tx_shift[15] on the same clk as the load.
  - sample(ch) = adc_data slice for ch, or 0x000 when ch >= NUM_CH.
- sclk rising in SHIFT: rx_shift <= {rx_shift[14:0], mosi_sync}; bit_cnt increments and saturates at FRAME_BITS.
- sclk falling in SHIFT: tx_shift shifts left by 1; miso = new tx_shift[15]. After 16 bits, miso = 0.
- Edges beyond 16 are ignored: rx_shift is not shifted and miso holds 0.
- ss rising with bit_cnt == 16 (DONE):
  - cmd_word <= rx_shift; cmd_valid pulses for 1 clk; frame_count increments.
  - Decode: if rx[15:12]==4'b0001 (manual) and rx[11]==1, then pending_ch <= rx[10:7].
  - Otherwise (mode 0000 continue, program bit 0, or any other mode) pending_ch is held.
- ss rising with bit_cnt < 16 (ABORT): frame_err pulses for 1 clk. cmd_word, cmd_valid, pending_ch and frame_count are unchanged. acq_ch keeps the value already loaded at ss falling.
- ss high: miso = 0. sclk edges while ss is high are ignored.
- Pipeline: a channel programmed in frame n is acquired in frame n+1 and returned in frame n+2. The first two frames after reset return ch0.
- adc_data is sampled only at the ss-falling load; changes mid-frame do not alter that frame's output.

Decomposition:
- Package ads7950_pkg holds:
  - FRAME_BITS.
  - Mode codes: MODE_CONTINUE=4'b0000, MODE_MANUAL=4'b0001.
  - Field positions: MODE[15:12], PROG[11], CHAN[10:7].
  - The state enum.
- One sub-module, spi_input_sync, contains the synchronizer and the edge detectors. It outputs sclk_rise, sclk_fall, ss_fall, ss_rise and mosi_s.

Test Plan:
- Setup for all frames below: adc_data ch0=0x123, ch1=0xABC, ch2=0x555, ch3=0xFFF.
- After reset, frame 1 with cmd 0x1880 (manual, ch1) -> miso 0x0123, cmd_word=0x1880, cmd_valid 1 pulse, frame_count=1.
- Frame 2 with cmd 0x1900 (ch2) -> miso 0x0123. Frame 3 with cmd 0x0000 -> miso 0x1ABC. Frame 4 with cmd 0x0000 -> miso 0x2555 (confirms the two-frame latency).
- Frame with cmd 0x1E00 (ch12, out of range), followed by two more frames -> the second of those returns 0xC000.
- ss high after 8 sclk edges -> frame_err 1 pulse; cmd_valid stays 0; frame_count and pending_ch unchanged; the next full frame decodes normally.
- 20 sclk edges in one frame with cmd 0x1900 -> first 16 bits are captured, miso=0 during edges 17-20, pending_ch=2.
- rst asserted at bit 9 of a frame -> all outputs at reset values the next clk; no frame_err; the following frame returns 0x0123.
